vectrex_cart_loader: RTL and testbench

- Sits between the mist_io ioctl download stream and the cartridge SDRAM port.
- Buffers downloaded cartridge bytes and issues handshaked SDRAM writes.
- Tracks the loaded cartridge size and masks console reads beyond it.
- Sequences the core reset after a download, including the optional delayed second reset that skips the boot logo.

---
 rtl/vectrex_cart_loader.sv | 206 ++++++++++++++++++++
 tb/tb_vectrex_cart_loader.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vectrex_cart_loader.sv
// Cartridge download path: buffers ioctl bytes into a small FIFO, writes them to SDRAM,
// masks reads past the loaded size and sequences the core reset. Optional: CART_CHECKSUM_EN.
module vectrex_cart_loader #(
   parameter int ADDR_W     = 15,
   parameter int FIFO_DEPTH = 4,
   parameter int RESET_LEN  = 1000,
   parameter int LOGO_DELAY = 5000000
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ioctl_download,
   input  logic              ioctl_wr,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   input  logic              skip_logo,
   input  logic              ext_reset_req,
   input  logic [ADDR_W-1:0] cart_addr,
   input  logic              cart_rd,
   input  logic [7:0]        mem_dout,
   input  logic              mem_ack,
   output logic [24:0]       mem_addr,
   output logic [7:0]        mem_din,
   output logic              mem_we,
   output logic              mem_rd,
   output logic [7:0]        cart_do,
   output logic [ADDR_W:0]   cart_size,
`ifdef CART_CHECKSUM_EN
   output logic [15:0]       cart_sum,
`endif
   output logic              overflow,
   output logic              core_reset,
   output logic              loading
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_MAX = (RESET_LEN > LOGO_DELAY) ? RESET_LEN : LOGO_DELAY;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(RESET_LEN);
   localparam logic [CNT_W-1:0] LOGO_LOAD = CNT_W'(LOGO_DELAY);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [PTR_W:0]   PTR_ONE   = (PTR_W + 1)'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_DRAIN,
      S_HOLD,
      S_LOGO_WAIT
   } state_t;

   state_t           r_state, w_state_next;
   logic [CNT_W-1:0] r_cnt, w_cnt_next;
   logic             r_skip, w_skip_next;
   logic             r_dl_prev;
   logic             r_core_reset;
   logic             w_dl_rise;
   logic             w_fifo_clear;

   logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
   logic [7:0]        r_fifo_data [FIFO_DEPTH];
   logic [PTR_W:0]    r_wr_ptr, r_rd_ptr;
   logic              r_mem_we;
   logic [ADDR_W:0]   r_cart_size;
   logic              r_overflow;

   logic              w_fifo_empty, w_fifo_full;
   logic              w_pop, w_push, w_drop, w_wr_evt, w_in_range;
   logic [ADDR_W-1:0] w_byte_addr;
   logic [ADDR_W:0]   w_addr_plus1;

   assign w_dl_rise    = ioctl_download & ~r_dl_prev;
   assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
   assign w_fifo_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                         (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
   assign w_pop        = r_mem_we & mem_ack;
   assign w_in_range   = (ioctl_addr[24:ADDR_W] == '0);
   assign w_wr_evt     = (r_state == S_LOAD) & ioctl_wr;
   // A full FIFO still accepts a byte when the head leaves in the same cycle.
   assign w_push       = w_wr_evt & w_in_range & (~w_fifo_full | w_pop);
   assign w_drop       = w_wr_evt & ~w_push;
   assign w_byte_addr  = ioctl_addr[ADDR_W-1:0];
   assign w_addr_plus1 = {1'b0, w_byte_addr} + {{ADDR_W{1'b0}}, 1'b1};

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_skip_next  = r_skip;
      w_fifo_clear = 1'b0;
      if (w_dl_rise) begin
         w_state_next = S_LOAD;
         w_skip_next  = skip_logo;
         w_fifo_clear = 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (ext_reset_req) begin
                  w_state_next = S_HOLD;
                  w_cnt_next   = RST_LOAD;
                  w_skip_next  = 1'b0;
               end
            end
            S_LOAD: begin
               if (!ioctl_download) w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
               if (w_fifo_empty && !r_mem_we) begin
                  w_state_next = S_HOLD;
                  w_cnt_next   = RST_LOAD;
               end
            end
            S_HOLD: begin
               if (ext_reset_req) begin
                  w_cnt_next  = RST_LOAD;
                  w_skip_next = 1'b0;
               end else if (r_cnt <= CNT_ONE) begin
                  // The logo-skip reset happens once per download.
                  if (r_skip) begin
                     w_state_next = S_LOGO_WAIT;
                     w_cnt_next   = LOGO_LOAD;
                     w_skip_next  = 1'b0;
                  end else begin
                     w_state_next = S_IDLE;
                  end
               end else begin
                  w_cnt_next = r_cnt - CNT_ONE;
               end
            end
            S_LOGO_WAIT: begin
               if (ext_reset_req) begin
                  w_state_next = S_HOLD;
                  w_cnt_next   = RST_LOAD;
                  w_skip_next  = 1'b0;
               end else if (r_cnt <= CNT_ONE) begin
                  w_state_next = S_HOLD;
                  w_cnt_next   = RST_LOAD;
               end else begin
                  w_cnt_next = r_cnt - CNT_ONE;
               end
            end
            default: w_state_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_cnt        <= RST_LOAD;
         r_skip       <= 1'b0;
         r_dl_prev    <= 1'b0;
         r_core_reset <= 1'b1;
      end else begin
         r_state      <= w_state_next;
         r_cnt        <= w_cnt_next;
         r_skip       <= w_skip_next;
         r_dl_prev    <= ioctl_download;
         r_core_reset <= (w_state_next == S_LOAD) || (w_state_next == S_DRAIN) ||
                         (w_state_next == S_HOLD);
      end
   end

   always_ff @(posedge clk_sys) begin
      if (w_push) begin
         r_fifo_addr[r_wr_ptr[PTR_W-1:0]] <= w_byte_addr;
         r_fifo_data[r_wr_ptr[PTR_W-1:0]] <= ioctl_dout;
      end
   end

   // Reset and download start both abandon any buffered or in-flight write.
   always_ff @(posedge clk_sys) begin
      if (reset || w_fifo_clear) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_mem_we    <= 1'b0;
         r_cart_size <= '0;
         r_overflow  <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         if (w_drop) r_overflow <= 1'b1;
         if (w_push && (w_addr_plus1 > r_cart_size)) r_cart_size <= w_addr_plus1;
         if (w_pop) r_mem_we <= 1'b0;
         else if (!r_mem_we && !w_fifo_empty) r_mem_we <= 1'b1;
      end
   end

`ifdef CART_CHECKSUM_EN
   logic [15:0] r_sum;
   always_ff @(posedge clk_sys) begin
      if (reset || w_fifo_clear) r_sum <= '0;
      else if (w_push) r_sum <= r_sum + {8'h00, ioctl_dout};
   end
   assign cart_sum = r_sum;
`endif

   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_we ? 25'(r_fifo_addr[r_rd_ptr[PTR_W-1:0]]) : 25'(cart_addr);
   assign mem_din    = r_fifo_data[r_rd_ptr[PTR_W-1:0]];
   assign mem_rd     = cart_rd & ((r_state == S_IDLE) || (r_state == S_LOGO_WAIT));
   assign cart_do    = ({1'b0, cart_addr} < r_cart_size) ? mem_dout : 8'hFF;
   assign cart_size  = r_cart_size;
   assign overflow   = r_overflow;
   assign core_reset = r_core_reset;
   assign loading    = (r_state == S_LOAD) || (r_state == S_DRAIN);

endmodule

// File: tb/tb_vectrex_cart_loader.sv
// Directed and randomized bench for vectrex_cart_loader against a queue-based
// download model; a background responder acknowledges SDRAM writes.
module tb_vectrex_cart_loader;

   localparam int AW = 15;
   localparam int RL = 12;
   localparam int LD = 40;

   logic          clk_sys = 1'b0;
   logic          reset, ioctl_download, ioctl_wr, skip_logo, ext_reset_req, cart_rd, mem_ack;
   logic [24:0]   ioctl_addr;
   logic [7:0]    ioctl_dout, mem_dout;
   logic [AW-1:0] cart_addr;
   logic [24:0]   mem_addr;
   logic [7:0]    mem_din, cart_do;
   logic          mem_we, mem_rd, overflow, core_reset, loading;
   logic [AW:0]   cart_size;
`ifdef CART_CHECKSUM_EN
   logic [15:0]   cart_sum;
`endif

   always #5 clk_sys = ~clk_sys;

   vectrex_cart_loader #(.ADDR_W(AW), .FIFO_DEPTH(4), .RESET_LEN(RL), .LOGO_DELAY(LD)) dut (
      .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .skip_logo(skip_logo),
      .ext_reset_req(ext_reset_req), .cart_addr(cart_addr), .cart_rd(cart_rd),
      .mem_dout(mem_dout), .mem_ack(mem_ack), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_we(mem_we), .mem_rd(mem_rd), .cart_do(cart_do), .cart_size(cart_size),
`ifdef CART_CHECKSUM_EN
      .cart_sum(cart_sum),
`endif
      .overflow(overflow), .core_reset(core_reset), .loading(loading)
   );

   int tests = 0;
   int failed = 0;

   // Model of the loaded cartridge.
   int          m_size;
   bit          m_ovf;
   logic [15:0] m_sum;
   logic [24:0] exp_addr[$];
   logic [7:0]  exp_data[$];
   logic [24:0] obs_addr[$];
   logic [7:0]  obs_data[$];

   int ack_lat = 2;
   bit ack_hold = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // SDRAM responder: acknowledges each write ack_lat cycles in, logging it.
   initial begin : responder
      int          ack_wait;
      bit          prev_we;
      logic [24:0] prev_addr;
      logic [7:0]  prev_data;
      ack_wait = 0;
      prev_we  = 1'b0;
      mem_ack  = 1'b0;
      forever begin
         @(negedge clk_sys);
         mem_ack = 1'b0;
         if (mem_we === 1'b1) begin
            if (prev_we) begin
               chk("wr_addr_stable", mem_addr, prev_addr);
               chk("wr_data_stable", mem_din, prev_data);
            end
            prev_we   = 1'b1;
            prev_addr = mem_addr;
            prev_data = mem_din;
            if (!ack_hold) begin
               if (ack_wait < ack_lat) ack_wait++;
               else begin
                  mem_ack = 1'b1;
                  obs_addr.push_back(mem_addr);
                  obs_data.push_back(mem_din);
                  ack_wait = 0;
                  prev_we  = 1'b0;
               end
            end
         end else begin
            prev_we  = 1'b0;
            ack_wait = 0;
         end
      end
   end

   task automatic start_dl(input bit skip);
      skip_logo      = skip;
      ioctl_download = 1'b1;
      m_size = 0;
      m_ovf  = 1'b0;
      m_sum  = '0;
      @(negedge clk_sys);
      @(negedge clk_sys);
      chk("load_core_reset", core_reset, 1);
      chk("load_loading", loading, 1);
   endtask

   task automatic model_byte(input logic [24:0] a, input logic [7:0] d, input bit room);
      if (a < 25'(1 << AW) && room) begin
         exp_addr.push_back(a);
         exp_data.push_back(d);
         if (int'(a) + 1 > m_size) m_size = int'(a) + 1;
         m_sum = m_sum + 16'(d);
      end else begin
         m_ovf = 1'b1;
      end
   endtask

   task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input int gap);
      ioctl_wr   = 1'b1;
      ioctl_addr = a;
      ioctl_dout = d;
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      model_byte(a, d, 1'b1);
      repeat (gap) @(negedge clk_sys);
   endtask

   task automatic end_dl_and_wait();
      int n;
      ioctl_download = 1'b0;
      @(negedge clk_sys);
      n = 0;
      while (loading === 1'b1 && n < 3000) begin
         @(negedge clk_sys);
         n++;
      end
      chk("drain_done", loading, 0);
   endtask

   task automatic count_level(input logic lvl, input int limit, output int n);
      n = 0;
      while (core_reset === lvl && n < limit) begin
         n++;
         @(negedge clk_sys);
      end
   endtask

   task automatic check_result(input string tag);
      int k;
      chk({tag, "_size"}, 32'(cart_size), m_size);
      chk({tag, "_ovf"}, overflow, m_ovf);
`ifdef CART_CHECKSUM_EN
      chk({tag, "_sum"}, cart_sum, m_sum);
`endif
      chk({tag, "_nwrites"}, obs_addr.size(), exp_addr.size());
      k = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
      for (int i = 0; i < k; i++) begin
         chk({tag, "_wr_addr"}, obs_addr[i], exp_addr[i]);
         chk({tag, "_wr_data"}, obs_data[i], exp_data[i]);
      end
      obs_addr.delete(); obs_data.delete();
      exp_addr.delete(); exp_data.delete();
   endtask

   task automatic read_check(input logic [AW-1:0] a);
      cart_addr = a;
      mem_dout  = 8'($urandom);
      #1;
      chk("rd_cart_do", cart_do, (int'(a) < m_size) ? mem_dout : 8'hFF);
      chk("rd_mem_addr", mem_addr, 25'(a));
      chk("rd_mem_rd", mem_rd, cart_rd);
   endtask

   initial begin : main
      int n;
      reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
      skip_logo = 1'b0; ext_reset_req = 1'b0; cart_addr = '0; cart_rd = 1'b0; mem_dout = '0;
      repeat (3) @(negedge clk_sys);
      chk("rst_core_reset", core_reset, 1);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_size", 32'(cart_size), 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_loading", loading, 0);
      reset = 1'b0;
      @(negedge clk_sys);
      chk("idle_core_reset", core_reset, 0);

      // Three-byte download, single reset hold.
      ack_lat = 2;
      start_dl(1'b0);
      send_byte(25'd0, 8'h11, 8);
      send_byte(25'd1, 8'h22, 8);
      send_byte(25'd2, 8'h33, 8);
      end_dl_and_wait();
      count_level(1'b1, 200, n);  chk("t1_hold_len", n, RL);
      count_level(1'b0, 150, n);  chk("t1_no_second", n, 150);
      check_result("t1");

      // Back-to-back bytes with acknowledges withheld: only four fit.
      ack_hold = 1'b1;
      start_dl(1'b0);
      for (int i = 0; i < 6; i++) begin
         ioctl_wr   = 1'b1;
         ioctl_addr = 25'(i);
         ioctl_dout = 8'($urandom);
         @(negedge clk_sys);
         model_byte(25'(i), ioctl_dout, i < 4);
      end
      ioctl_wr = 1'b0;
      chk("t2_ovf_now", overflow, 1);
      chk("t2_we_waiting", mem_we, 1);
      repeat (20) @(negedge clk_sys);
      ack_hold = 1'b0;
      ack_lat  = 1;
      end_dl_and_wait();
      count_level(1'b1, 200, n);  chk("t2_hold_len", n, RL);
      check_result("t2");

      // Address beyond the cartridge window.
      start_dl(1'b0);
      send_byte(25'd5, 8'hA5, 8);
      send_byte(25'h8000, 8'h5A, 8);
      chk("t3_ovf_now", overflow, 1);
      chk("t3_size_now", 32'(cart_size), 6);
      end_dl_and_wait();
      count_level(1'b1, 200, n);  chk("t3_hold_len", n, RL);
      check_result("t3");

      // 0x1000-byte image, then reads around its end.
      start_dl(1'b0);
      send_byte(25'h0FFF, 8'($urandom), 8);
      send_byte(25'($urandom_range(0, 32'h0FFE)), 8'($urandom), 8);
      end_dl_and_wait();
      count_level(1'b1, 200, n);  chk("t4_hold_len", n, RL);
      check_result("t4");
      cart_rd = 1'b1;
      read_check(15'h0FFF);
      read_check(15'h1000);
      read_check(15'h0000);
      read_check(15'h7FFF);
      cart_rd = 1'b0;

      // Logo-skip sequence: hold, wait, hold again, then idle.
      start_dl(1'b1);
      send_byte(25'd7, 8'h77, 8);
      cart_rd = 1'b1;
      end_dl_and_wait();
      chk("t5_rd_blocked_hold", mem_rd, 0);
      count_level(1'b1, 200, n);  chk("t5_hold1", n, RL);
      chk("t5_rd_logo_wait", mem_rd, 1);
      count_level(1'b0, 200, n);  chk("t5_logo_wait", n, LD);
      count_level(1'b1, 200, n);  chk("t5_hold2", n, RL);
      count_level(1'b0, 150, n);  chk("t5_idle", n, 150);
      cart_rd = 1'b0;
      check_result("t5");

      // ext_reset_req ignored while loading.
      start_dl(1'b0);
      ext_reset_req = 1'b1;
      repeat (3) @(negedge clk_sys);
      chk("t6_ext_load_loading", loading, 1);
      chk("t6_ext_load_core", core_reset, 1);
      ext_reset_req = 1'b0;
      send_byte(25'd3, 8'h3C, 8);
      end_dl_and_wait();
      count_level(1'b1, 200, n);  chk("t6_hold_len", n, RL);
      check_result("t6");

      // ext_reset_req in LOGO_WAIT: immediate hold, no logo reset afterwards.
      start_dl(1'b1);
      send_byte(25'd9, 8'h99, 8);
      end_dl_and_wait();
      count_level(1'b1, 200, n);  chk("t7_hold1", n, RL);
      repeat (5) @(negedge clk_sys);
      chk("t7_in_logo_wait", core_reset, 0);
      ext_reset_req = 1'b1;
      @(negedge clk_sys);
      ext_reset_req = 1'b0;
      chk("t7_ext_immediate", core_reset, 1);
      count_level(1'b1, 200, n);  chk("t7_ext_hold", n, RL);
      count_level(1'b0, 150, n);  chk("t7_no_logo", n, 150);
      check_result("t7");

      // Reset while draining abandons the queued writes.
      ack_hold = 1'b1;
      start_dl(1'b0);
      send_byte(25'd1, 8'h01, 1);
      send_byte(25'd2, 8'h02, 1);
      send_byte(25'd3, 8'h03, 1);
      ioctl_download = 1'b0;
      @(negedge clk_sys);
      chk("t8_draining", loading, 1);
      chk("t8_we_pending", mem_we, 1);
      reset = 1'b1;
      @(negedge clk_sys);
      chk("t8_we_dropped", mem_we, 0);
      chk("t8_idle", loading, 0);
      chk("t8_core_reset", core_reset, 1);
      reset = 1'b0;
      ack_hold = 1'b0;
      exp_addr.delete(); exp_data.delete();
      m_size = 0; m_ovf = 1'b0; m_sum = '0;
      repeat (10) @(negedge clk_sys);
      chk("t8_fifo_empty", mem_we, 0);
      check_result("t8");

      // Randomized downloads.
      for (int it = 0; it < 6; it++) begin
         bit skip;
         int nb;
         skip    = 1'($urandom);
         ack_lat = $urandom_range(0, 3);
         start_dl(skip);
         nb = $urandom_range(1, 6);
         for (int j = 0; j < nb; j++) begin
            logic [24:0] a;
            a = ($urandom_range(0, 7) == 0) ? 25'(32'h8000 + $urandom_range(0, 999))
                                             : 25'($urandom_range(0, 32'h7FFF));
            send_byte(a, 8'($urandom), 10);
         end
         end_dl_and_wait();
         count_level(1'b1, 200, n);  chk("rnd_hold1", n, RL);
         if (skip) begin
            count_level(1'b0, 200, n);  chk("rnd_logo_wait", n, LD);
            count_level(1'b1, 200, n);  chk("rnd_hold2", n, RL);
         end
         count_level(1'b0, 60, n);  chk("rnd_idle", n, 60);
         check_result("rnd");
         cart_rd = 1'b1;
         for (int j = 0; j < 3; j++) read_check(AW'($urandom));
         if (m_size > 0) read_check(AW'(m_size - 1));
         if (m_size < (1 << AW)) read_check(AW'(m_size));
         cart_rd = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
